// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt controller: Status/Cause/EPC, interrupt sampling, and the
// entry/return redirect sequencing at the MEM-stage instruction boundary.
module cp0_int_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
    parameter int          NUM_EXT    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timer_int,
    input  logic [NUM_EXT-1:0] ext_int,
    input  logic               inst_valid,
    input  logic [31:0]        inst_pc,
    input  logic               in_delay_slot,
    input  logic               eret,
    input  logic               mtc0_we,
    input  logic [4:0]         mtc0_addr,
    input  logic [31:0]        mtc0_data,
    input  logic [4:0]         mfc0_addr,
    output logic [31:0]        mfc0_data,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic               exl,
    output logic               int_pending
);
    typedef enum logic [1:0] {S_RUN, S_ENTER, S_HANDLER, S_RETURN} state_t;

    state_t             r_state;
    logic               r_ie;
    logic               r_exl;
    logic [7:0]         r_im;
    logic               r_bd;
    logic [31:0]        r_epc;
    logic [NUM_EXT-1:0] r_sync1;
    logic [NUM_EXT-1:0] r_sync2;
    logic               r_redirect;
    logic [31:0]        r_redirect_pc;

    logic [7:0]         w_ip;
    logic               w_take;
    logic               w_eret;
    logic               w_mtc0;
    logic [31:0]        w_status;
    logic [31:0]        w_cause;

    // Timer feeds IP7 unsynchronized (same clock domain); externals go through the synchronizer.
    always_comb begin
        w_ip              = '0;
        w_ip[7]           = timer_int;
        w_ip[2 +: NUM_EXT] = r_sync2;
    end

    assign int_pending = |(w_ip & r_im);
    assign w_take      = (r_state == S_RUN) & inst_valid & r_ie & ~r_exl & int_pending;
    assign w_eret      = (r_state == S_HANDLER) & inst_valid & eret;
    // MTC0 only lands when no take/eret flushes it; ENTER/RETURN cycles are being flushed.
    assign w_mtc0      = inst_valid & mtc0_we &
                         (((r_state == S_RUN) & ~w_take) | ((r_state == S_HANDLER) & ~w_eret));

    assign w_status = {16'b0, r_im, 6'b0, r_exl, r_ie};
    assign w_cause  = {r_bd, 15'b0, w_ip, 8'b0};

    always_comb begin
        mfc0_data = '0;
        case (mfc0_addr)
            5'd12:   mfc0_data = w_status;
            5'd13:   mfc0_data = w_cause;
            5'd14:   mfc0_data = r_epc;
            default: mfc0_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_ie          <= 1'b0;
            r_exl         <= 1'b0;
            r_im          <= '0;
            r_bd          <= 1'b0;
            r_epc         <= '0;
            r_sync1       <= '0;
            r_sync2       <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_sync1    <= ext_int;
            r_sync2    <= r_sync1;
            r_redirect <= 1'b0;
            if (w_mtc0) begin
                if (mtc0_addr == 5'd12) begin
                    r_ie  <= mtc0_data[0];
                    r_exl <= mtc0_data[1];
                    r_im  <= mtc0_data[15:8];
                end
                if (mtc0_addr == 5'd14)
                    r_epc <= mtc0_data;
            end
            case (r_state)
                S_RUN: begin
                    if (w_take) begin
                        r_exl         <= 1'b1;
                        r_bd          <= in_delay_slot;
                        r_epc         <= in_delay_slot ? inst_pc - 32'd4 : inst_pc;
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= EXC_VECTOR;
                        r_state       <= S_ENTER;
                    end
                end
                S_ENTER: r_state <= S_HANDLER;
                S_HANDLER: begin
                    if (w_eret) begin
                        r_exl         <= 1'b0;
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= r_epc;
                        r_state       <= S_RETURN;
                    end else if (w_mtc0 && mtc0_addr == 5'd12 && !mtc0_data[1]) begin
                        r_state <= S_RUN;
                    end
                end
                S_RETURN: r_state <= S_RUN;
                default:  r_state <= S_RUN;
            endcase
        end
    end

    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign exl         = r_exl;
endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed bench for cp0_int_ctrl: entry, delay slot, masking, sync latency,
// ERET return spacing, MTC0 collisions and mid-sequence reset.
module tb_cp0_int_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        timer_int;
    logic [4:0]  ext_int;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic        in_delay_slot;
    logic        eret;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_data;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exl;
    logic        int_pending;

    int n_cmp = 0;
    int n_err = 0;

    cp0_int_ctrl dut (
        .clk(clk), .rst(rst), .timer_int(timer_int), .ext_int(ext_int),
        .inst_valid(inst_valid), .inst_pc(inst_pc), .in_delay_slot(in_delay_slot),
        .eret(eret), .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
        .mfc0_addr(mfc0_addr), .mfc0_data(mfc0_data), .redirect(redirect),
        .redirect_pc(redirect_pc), .exl(exl), .int_pending(int_pending)
    );

    always #10 clk = ~clk;

    task step();
        @(posedge clk); #2;
    endtask

    task rd(input logic [4:0] a, output logic [31:0] d);
        mfc0_addr = a; #1; d = mfc0_data;
    endtask

    task idle();
        timer_int = 0; ext_int = '0; inst_valid = 0; inst_pc = '0; in_delay_slot = 0;
        eret = 0; mtc0_we = 0; mtc0_addr = '0; mtc0_data = '0; mfc0_addr = '0;
    endtask

    task do_reset();
        idle();
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        step();
    endtask

    task mtc0(input logic [4:0] a, input logic [31:0] d);
        inst_valid = 1; mtc0_we = 1; mtc0_addr = a; mtc0_data = d;
        step();
        inst_valid = 0; mtc0_we = 0;
    endtask

    // Leaves the DUT in the cycle where the entry redirect is high (ENTER).
    task enter_timer(input logic [31:0] pc);
        mtc0(5'd12, 32'h0000_8001);
        timer_int = 1; inst_valid = 1; inst_pc = pc;
        step();
        inst_valid = 0;
    endtask

    task test_reset();
        logic [31:0] d;
        idle();
        rst = 1; #1;
        n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL reset_redirect: got %b want 0", redirect); end
        n_cmp++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
        n_cmp++; if (exl !== 1'b0) begin n_err++; $display("FAIL reset_exl: got %b want 0", exl); end
        n_cmp++; if (int_pending !== 1'b0) begin n_err++; $display("FAIL reset_int_pending: got %b want 0", int_pending); end
        rd(5'd12, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h want 0", d); end
        rd(5'd13, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_cause: got %h want 0", d); end
        rd(5'd14, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_epc: got %h want 0", d); end
        @(negedge clk); rst = 0;
        step();
    endtask

    task test_timer_entry();
        logic [31:0] d;
        do_reset();
        mtc0(5'd12, 32'h0000_8001);
        rd(5'd12, d);
        n_cmp++; if (d !== 32'h0000_8001) begin n_err++; $display("FAIL te_status_wr: got %h want 00008001", d); end
        timer_int = 1; inst_valid = 1; inst_pc = 32'h40; #1;
        n_cmp++; if (int_pending !== 1'b1) begin n_err++; $display("FAIL te_pending: got %b want 1", int_pending); end
        step();
        inst_valid = 0;
        n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL te_redirect: got %b want 1", redirect); end
        n_cmp++; if (redirect_pc !== 32'h180) begin n_err++; $display("FAIL te_redirect_pc: got %h want 00000180", redirect_pc); end
        n_cmp++; if (exl !== 1'b1) begin n_err++; $display("FAIL te_exl: got %b want 1", exl); end
        rd(5'd14, d);
        n_cmp++; if (d !== 32'h40) begin n_err++; $display("FAIL te_epc: got %h want 00000040", d); end
        rd(5'd13, d);
        n_cmp++; if (d !== 32'h0000_8000) begin n_err++; $display("FAIL te_cause: got %h want 00008000", d); end
        rd(5'd12, d);
        n_cmp++; if (d !== 32'h0000_8003) begin n_err++; $display("FAIL te_status_exl: got %h want 00008003", d); end
        timer_int = 0;
        step();
        n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL te_pulse_one_cycle: got %b want 0", redirect); end
        n_cmp++; if (exl !== 1'b1) begin n_err++; $display("FAIL te_exl_held: got %b want 1", exl); end
    endtask

    task test_delay_slot();
        logic [31:0] d;
        do_reset();
        mtc0(5'd12, 32'h0000_8001);
        timer_int = 1; inst_valid = 1; inst_pc = 32'h44; in_delay_slot = 1;
        step();
        inst_valid = 0; in_delay_slot = 0;
        n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL ds_redirect: got %b want 1", redirect); end
        rd(5'd14, d);
        n_cmp++; if (d !== 32'h40) begin n_err++; $display("FAIL ds_epc: got %h want 00000040", d); end
        rd(5'd13, d);
        n_cmp++; if (d !== 32'h8000_8000) begin n_err++; $display("FAIL ds_cause: got %h want 80008000", d); end
    endtask

    task test_masking();
        logic [31:0] st [3];
        logic [31:0] d;
        int cnt;
        st[0] = 32'h0000_8000; st[1] = 32'h0000_0401; st[2] = 32'h0000_8003;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            mtc0(5'd12, st[k]);
            timer_int = 1; inst_valid = 1; inst_pc = 32'h40;
            cnt = 0;
            repeat (10) begin
                step();
                if (redirect) cnt++;
            end
            n_cmp++; if (cnt !== 0) begin n_err++; $display("FAIL mask_redirect[%0d]: got %0d redirects want 0", k, cnt); end
            rd(5'd13, d);
            n_cmp++; if (d !== 32'h0000_8000) begin n_err++; $display("FAIL mask_cause_ip7[%0d]: got %h want 00008000", k, d); end
            timer_int = 0; inst_valid = 0;
        end
    endtask

    task test_ext_sync();
        logic [31:0] d;
        do_reset();
        mtc0(5'd12, 32'h0000_0401);
        inst_valid = 1; inst_pc = 32'h60; ext_int = 5'b00001;
        step();
        rd(5'd13, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL ext_c1_cause: got %h want 0", d); end
        n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL ext_c1_redirect: got %b want 0", redirect); end
        step();
        rd(5'd13, d);
        n_cmp++; if (d !== 32'h0000_0400) begin n_err++; $display("FAIL ext_c2_cause: got %h want 00000400", d); end
        n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL ext_c2_redirect: got %b want 0", redirect); end
        step();
        n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL ext_c3_redirect: got %b want 1", redirect); end
        n_cmp++; if (redirect_pc !== 32'h180) begin n_err++; $display("FAIL ext_c3_pc: got %h want 00000180", redirect_pc); end
        rd(5'd14, d);
        n_cmp++; if (d !== 32'h60) begin n_err++; $display("FAIL ext_epc: got %h want 00000060", d); end
        inst_valid = 0; ext_int = '0;
    endtask

    task test_eret();
        logic [31:0] d;
        do_reset();
        enter_timer(32'h40);
        step();
        eret = 1; inst_valid = 1; inst_pc = 32'h100;
        step();
        eret = 0; inst_pc = 32'h48;
        n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL eret_redirect: got %b want 1", redirect); end
        n_cmp++; if (redirect_pc !== 32'h40) begin n_err++; $display("FAIL eret_pc: got %h want 00000040", redirect_pc); end
        n_cmp++; if (exl !== 1'b0) begin n_err++; $display("FAIL eret_exl: got %b want 0", exl); end
        step();
        n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL eret_return_gap: got %b want 0", redirect); end
        step();
        n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL eret_retake: got %b want 1", redirect); end
        n_cmp++; if (redirect_pc !== 32'h180) begin n_err++; $display("FAIL eret_retake_pc: got %h want 00000180", redirect_pc); end
        rd(5'd14, d);
        n_cmp++; if (d !== 32'h48) begin n_err++; $display("FAIL eret_retake_epc: got %h want 00000048", d); end
        inst_valid = 0; timer_int = 0;
    endtask

    task test_collision_reset();
        logic [31:0] d;
        do_reset();
        mtc0(5'd12, 32'h0000_8001);
        timer_int = 1; inst_valid = 1; inst_pc = 32'h80;
        mtc0_we = 1; mtc0_addr = 5'd14; mtc0_data = 32'hDEAD;
        step();
        inst_valid = 0; mtc0_we = 0;
        n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL col_redirect: got %b want 1", redirect); end
        rd(5'd14, d);
        n_cmp++; if (d !== 32'h80) begin n_err++; $display("FAIL col_epc: got %h want 00000080", d); end
        rst = 1; #1;
        n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL rst_enter_redirect: got %b want 0", redirect); end
        n_cmp++; if (exl !== 1'b0) begin n_err++; $display("FAIL rst_enter_exl: got %b want 0", exl); end
        rd(5'd12, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_enter_status: got %h want 0", d); end
        rd(5'd14, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_enter_epc: got %h want 0", d); end
        @(negedge clk); rst = 0;
        step();
        mtc0(5'd12, 32'h0000_8001);
        n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL rst_ie_off_take: got %b want 0", redirect); end
        inst_valid = 1; inst_pc = 32'h84;
        step();
        n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL rst_state_run: got %b want 1", redirect); end
        inst_valid = 0; timer_int = 0;
    endtask

    task test_handler_priority();
        logic [31:0] d;
        do_reset();
        enter_timer(32'h40);
        step();
        timer_int = 0;
        eret = 1; inst_valid = 1; mtc0_we = 1; mtc0_addr = 5'd14; mtc0_data = 32'h1234;
        step();
        eret = 0; inst_valid = 0; mtc0_we = 0;
        n_cmp++; if (redirect_pc !== 32'h40) begin n_err++; $display("FAIL hp_redirect_pc: got %h want 00000040", redirect_pc); end
        rd(5'd14, d);
        n_cmp++; if (d !== 32'h40) begin n_err++; $display("FAIL hp_epc_kept: got %h want 00000040", d); end
        rd(5'd9, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mfc0_other: got %h want 0", d); end
    endtask

    task test_mtc0_exit();
        do_reset();
        enter_timer(32'h40);
        step();
        mtc0(5'd12, 32'h0000_8001);
        n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL mx_no_redirect: got %b want 0", redirect); end
        n_cmp++; if (exl !== 1'b0) begin n_err++; $display("FAIL mx_exl: got %b want 0", exl); end
        inst_valid = 1; inst_pc = 32'h50;
        step();
        n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL mx_retake: got %b want 1", redirect); end
        inst_valid = 0; timer_int = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_timer_entry();
        test_delay_slot();
        test_masking();
        test_ext_sync();
        test_eret();
        test_collision_reset();
        test_handler_priority();
        test_mtc0_exit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
